// File: rtl/johnson_pkg.sv
// Shared Johnson-code definitions: lock FSM states, successor and legality/decode helpers.
// Helpers operate on a fixed maximum width; callers zero-extend codes narrower than JPD_MAX_N.
package johnson_pkg;

  localparam int JPD_MAX_N = 16;

  typedef logic [JPD_MAX_N-1:0] jcode_t;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } jpd_state_e;

  typedef struct packed {
    logic       legal;
    logic [4:0] idx;
  } jdecode_t;

  // Shift right by one and feed the inverted LSB back into bit n-1.
  function automatic jcode_t jpd_successor(input jcode_t c, input int n);
    jcode_t s;
    s = '0;
    for (int b = 0; b < JPD_MAX_N - 1; b++) begin
      if (b < n - 1) s[b] = c[b+1];
    end
    s[n-1] = ~c[0];
    return s;
  endfunction

  // Walks the 2n legal codes starting from all-zero; the position of a match is the phase.
  function automatic jdecode_t jpd_decode(input jcode_t c, input int n);
    jdecode_t d;
    jcode_t   code;
    d    = '0;
    code = '0;
    for (int p = 0; p < 2 * JPD_MAX_N; p++) begin
      if ((p < 2 * n) && (c == code) && !d.legal) begin
        d.legal = 1'b1;
        d.idx   = 5'(p);
      end
      code = jpd_successor(code, n);
    end
    return d;
  endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Sample/result bundle for johnson_phase_decoder; err_cnt exists only when JPD_ERR_CNT_EN is defined.
interface johnson_phase_decoder_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(2 * N);

  logic              in_valid;
  logic [N-1:0]      in_code;
  logic [2*N-1:0]    phase_onehot;
  logic [IW-1:0]     phase_idx;
  logic              locked;
  logic              illegal;
  logic              seq_err;
`ifdef JPD_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  modport master (
    output in_valid, in_code,
`ifdef JPD_ERR_CNT_EN
    input  err_cnt,
`endif
    input  phase_onehot, phase_idx, locked, illegal, seq_err
  );

  modport slave (
    input  in_valid, in_code,
`ifdef JPD_ERR_CNT_EN
    output err_cnt,
`endif
    output phase_onehot, phase_idx, locked, illegal, seq_err
  );

endinterface

// File: rtl/johnson_code_check.sv
// Combinational Johnson code classifier: legal flag and phase index for an N-bit code.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code_i,
  output logic          legal_o,
  output logic [IW-1:0] idx_o
);

  jcode_t   codeExt;
  jdecode_t dec;

  always_comb begin
    codeExt          = '0;
    codeExt[N-1:0]   = code_i;
    dec              = jpd_decode(codeExt, N);
    legal_o          = dec.legal;
    idx_o            = IW'(dec.idx);
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder with sequence checking and a lock FSM.
// Optional saturating error counter enabled by defining JPD_ERR_CNT_EN.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  johnson_phase_decoder_if.slave  bus
);

  localparam int          IW        = $clog2(2 * N);
  localparam logic [3:0]  LOCK_LAST = 4'(LOCK_CNT - 1);

  logic             legal;
  logic [IW-1:0]    idx;
  jcode_t           prevExt;
  logic [N-1:0]     succ;
  logic [2*N-1:0]   phase_onehot_d;
  logic             isIllegal;
  logic             isSeqErr;
  logic             isGood;

  jpd_state_e       state_q;
  logic [3:0]       good_q;
  logic [N-1:0]     prev_q;
  logic             prev_valid_q;
  logic [2*N-1:0]   phase_onehot_q;
  logic [IW-1:0]    phase_idx_q;
  logic             locked_q;
  logic             illegal_q;
  logic             seq_err_q;
`ifdef JPD_ERR_CNT_EN
  logic [7:0]       err_cnt_q;
`endif

  johnson_code_check #(.N(N), .IW(IW)) u_check (
    .code_i  (bus.in_code),
    .legal_o (legal),
    .idx_o   (idx)
  );

  // A repeated code is not the successor, so it falls out as a sequence error here too.
  always_comb begin
    prevExt          = '0;
    prevExt[N-1:0]   = prev_q;
    succ             = N'(jpd_successor(prevExt, N));
    phase_onehot_d   = '0;
    phase_onehot_d[idx] = legal;
    isIllegal        = bus.in_valid && !legal;
    isSeqErr         = bus.in_valid && legal && prev_valid_q && (bus.in_code != succ);
    isGood           = bus.in_valid && legal && prev_valid_q && (bus.in_code == succ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ACQUIRE;
      good_q         <= '0;
      prev_q         <= '0;
      prev_valid_q   <= 1'b0;
      phase_onehot_q <= '0;
      phase_idx_q    <= '0;
      locked_q       <= 1'b0;
      illegal_q      <= 1'b0;
      seq_err_q      <= 1'b0;
`ifdef JPD_ERR_CNT_EN
      err_cnt_q      <= '0;
`endif
    end else begin
      illegal_q <= isIllegal;
      seq_err_q <= isSeqErr;

      if (bus.in_valid) begin
        phase_onehot_q <= phase_onehot_d;
        if (legal) begin
          phase_idx_q  <= idx;
          prev_q       <= bus.in_code;
          prev_valid_q <= 1'b1;
        end else begin
          prev_valid_q <= 1'b0;
        end
      end

`ifdef JPD_ERR_CNT_EN
      if ((isIllegal || isSeqErr) && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
`endif

      case (state_q)
        ACQUIRE: begin
          if (isIllegal || isSeqErr) begin
            good_q <= '0;
          end else if (isGood) begin
            if (good_q == LOCK_LAST) begin
              state_q  <= LOCKED;
              good_q   <= '0;
              locked_q <= 1'b1;
            end else begin
              good_q <= good_q + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (isIllegal || isSeqErr) begin
            state_q  <= ACQUIRE;
            good_q   <= '0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ACQUIRE;
          good_q   <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase_onehot = phase_onehot_q;
  assign bus.phase_idx    = phase_idx_q;
  assign bus.locked       = locked_q;
  assign bus.illegal      = illegal_q;
  assign bus.seq_err      = seq_err_q;
`ifdef JPD_ERR_CNT_EN
  assign bus.err_cnt      = err_cnt_q;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed self-checking bench for johnson_phase_decoder (N=4, LOCK_CNT=3).
module tb_johnson_phase_decoder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  johnson_phase_decoder_if #(.N(4)) bus ();

  johnson_phase_decoder #(.N(4), .LOCK_CNT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] eOh, input logic [2:0] eIdx,
                             input logic eLk, input logic eIll, input logic eSeq);
    checkOne({tag, ".onehot"},  32'(bus.phase_onehot), 32'(eOh));
    checkOne({tag, ".idx"},     32'(bus.phase_idx),    32'(eIdx));
    checkOne({tag, ".locked"},  32'(bus.locked),       32'(eLk));
    checkOne({tag, ".illegal"}, 32'(bus.illegal),      32'(eIll));
    checkOne({tag, ".seq_err"}, 32'(bus.seq_err),      32'(eSeq));
  endtask

  // Drive one cycle of inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [3:0] code);
    @(negedge clk);
    reset        = rst;
    bus.in_valid = valid;
    bus.in_code  = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_code  = 4'b0000;

    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b1000);
    checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef JPD_ERR_CNT_EN
    checkOne("reset.err_cnt", 32'(bus.err_cnt), 32'd0);
`endif

    applyStimulus(1'b0, 1'b1, 4'b0000); checkOutput("acq0",  8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1000); checkOutput("acq1",  8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1100); checkOutput("acq2",  8'h04, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1110); checkOutput("lock",  8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0101); checkOutput("gapLk", 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111); checkOutput("ph4",   8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0111); checkOutput("ph5",   8'h20, 3'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0011); checkOutput("ph6",   8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0001); checkOutput("ph7",   8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000); checkOutput("wrap",  8'h01, 3'd0, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'b1000); checkOutput("re1",   8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1100); checkOutput("re2",   8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1010); checkOutput("illeg", 8'h00, 3'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1110); checkOutput("postIl",8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111); checkOutput("rl1",   8'h10, 3'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0111); checkOutput("rl2",   8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0011); checkOutput("relock",8'h40, 3'd6, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'b0001); checkOutput("s7",    8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000); checkOutput("s0",    8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1000); checkOutput("s1",    8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1100); checkOutput("s2",    8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111); checkOutput("skip",  8'h10, 3'd4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0111); checkOutput("k1",    8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0011); checkOutput("k2",    8'h40, 3'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0001); checkOutput("k3lock",8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0001); checkOutput("repeat",8'h80, 3'd7, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b0001); checkOutput("pulse", 8'h80, 3'd7, 1'b0, 1'b0, 1'b0);

    // Reset mid-sequence, then a gap in in_valid must be tolerated.
    applyStimulus(1'b1, 1'b1, 4'b0000); checkOutput("midRst",8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000); checkOutput("g0",    8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1000); checkOutput("g1",    8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b1010);
      checkOutput("gap", 8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 4'b1100); checkOutput("g2",    8'h04, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1110); checkOutput("g3lock",8'h08, 3'd3, 1'b1, 1'b0, 1'b0);

`ifdef JPD_ERR_CNT_EN
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOne("cnt.start", 32'(bus.err_cnt), 32'd0);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b0, 1'b1, 4'b1010);
      applyStimulus(1'b0, 1'b1, 4'b0000);
      if (i == 1 || i == 254 || i == 255 || i == 300) begin
        checkOne("cnt.step", 32'(bus.err_cnt), 32'((i > 255) ? 255 : i));
      end
    end
    applyStimulus(1'b0, 1'b1, 4'b1010);
    checkOne("cnt.sat", 32'(bus.err_cnt), 32'd255);
    checkOne("cnt.ill", 32'(bus.illegal), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b1010);
    checkOne("cnt.rst", 32'(bus.err_cnt), 32'd0);
    checkOutput("cntRst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 Parameter N, default 4: Johnson counter width in bits; 2N legal states; N>=2 SHALL hold.
REQ-002 Parameter LOCK_CNT, default 3: consecutive correct transitions required to assert locked; range 1..15.
REQ-003 clk  input  1: clock, all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset; clock is clk.
REQ-005 in_valid  input  1: in_code carries a sample this cycle.
REQ-006 in_code  input  N: Johnson counter output from the upstream counter stage.
REQ-007 phase_onehot  output  2N: registered one-hot decoded phase; bit k set for phase k.
REQ-008 phase_idx  output  $clog2(2N): registered binary phase index, 0..2N-1.
REQ-009 locked  output  1: registered; high while the FSM is in LOCKED.
REQ-010 illegal  output  1: registered one-cycle pulse; the sampled code is not one of the 2N legal codes.
REQ-011 seq_err  output  1: registered one-cycle pulse; the sampled code is legal but not the successor of the previous legal sample.
REQ-012 err_cnt  output  8: saturating error count; present only with JPD_ERR_CNT_EN.

Function
REQ-013 Legal codes SHALL be: k leading ones (bits N-1..N-k) with the rest zero -> phase k, k=0..N; m trailing ones (bits m-1..0) with MSB zero -> phase 2N-m, m=1..N-1.
REQ-014 Successor of code c SHALL be {~c[0], c[N-1:1]}; e.g. for N=4, phases 0..7 = 0000,1000,1100,1110,1111,0111,0011,0001, then wrap to 0000.
REQ-015 Latency SHALL be 1 cycle: outputs reflect the in_code sampled on the previous edge with in_valid=1.
REQ-016 in_valid=0: phase_onehot, phase_idx and locked SHALL hold; illegal and seq_err SHALL be 0; stored previous code SHALL be unchanged (gaps tolerated).
REQ-017 Illegal sample: phase_onehot SHALL be all zero, phase_idx SHALL hold its last value, illegal=1, and the stored previous code SHALL be marked invalid.
REQ-018 Legal sample with a valid stored previous code: seq_err=1 if it differs from the successor of the stored code; a repeat of the same code SHALL also flag seq_err.
REQ-019 Legal sample with no valid stored previous code (first after reset or after illegal): decode only, no seq_err; store the code as previous.
REQ-020 illegal has priority: seq_err SHALL never assert in the same cycle as illegal.
REQ-021 FSM states: ACQUIRE and LOCKED. ACQUIRE increments a good-transition counter on each correct successor; on reaching LOCK_CNT -> LOCKED, counter cleared.
REQ-022 In ACQUIRE, any illegal or seq_err event SHALL clear the good-transition counter; a legal first sample SHALL leave it at 0.
REQ-023 LOCKED -> ACQUIRE on any illegal or seq_err event; locked SHALL drop in the same registered update that pulses the error.
REQ-024 The wrap from phase 2N-1 to phase 0 SHALL count as a correct transition.

Reset
REQ-025 reset SHALL set phase_onehot=0, phase_idx=0, locked=0, illegal=0, seq_err=0, err_cnt=0, FSM=ACQUIRE, good counter=0, previous code invalid.
REQ-026 reset SHALL dominate in_valid in the same cycle; reset mid-sequence SHALL discard all lock history.

Configuration
REQ-027 Macro JPD_ERR_CNT_EN defined: err_cnt port present, increments by 1 on each illegal or seq_err pulse, saturates at 255, cleared only by reset.
REQ-028 Macro JPD_ERR_CNT_EN undefined: err_cnt port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package johnson_pkg SHALL hold the FSM state enum (ACQUIRE, LOCKED) and the successor and legality/decode functions, shared with the upstream counter bench.
REQ-030 One combinational sub-module johnson_code_check SHALL compute legal flag and phase index from in_code; the top holds all registers and the FSM.

Verification (N=4, LOCK_CNT=3)
REQ-031 Reset, then feed 0000,1000,1100,1110 valid each cycle -> phase_idx 0,1,2,3; locked rises on the edge after 1110 is sampled.
REQ-032 Locked, feed 0001 then 0000 -> phase_onehot 8'h80 then 8'h01, no seq_err, locked stays 1 (wrap).
REQ-033 Locked at 1100, feed 1010 -> illegal=1 one cycle, phase_onehot=0, seq_err=0, locked=0; next 1110 decodes without seq_err.
REQ-034 Locked at 1100, feed 1111 -> seq_err=1, phase_idx=4, locked=0; then 0111,0011,0001 -> locked=1 again.
REQ-035 Sequence 0000,1000, in_valid=0 for 5 cycles, 1100 -> outputs hold during gap, no error on 1100.
REQ-036 With JPD_ERR_CNT_EN, drive 300 alternating 1010/0000 samples -> err_cnt saturates at 255; reset mid-stream clears all outputs and err_cnt.
